axo_wb_arbiter: RTL

//  Shares the single register-file write port between NREQ writeback requesters (ALU, LSU, CSR unit).
//  - Round-robin arbitration with a valid/ready handshake; the winner goes through one register stage onto rf_we/rf_rd/rf_din.
//  - Keeps a 32-entry pending-write scoreboard: issue claims rd, writeback clears it. The issue stage stalls on busy operands.

---
 rtl/axo_defines.sv | 9 +
 rtl/axo_rr_arbiter.sv | 31 +++
 rtl/axo_wb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/axo_defines.sv
// rtl/axo_defines.sv - register index width, register count and index type
package axo_defines;

    localparam int AXO_REGIDX_W = 5;
    localparam int AXO_NREGS    = 32;

    typedef logic [AXO_REGIDX_W-1:0] axo_regidx_t;

endpackage

// File: rtl/axo_rr_arbiter.sv
// rtl/axo_rr_arbiter.sv - combinational round-robin picker, search starts at ptr and wraps at N
module axo_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/axo_wb_arbiter.sv
// rtl/axo_wb_arbiter.sv - writeback port arbiter with pending-write scoreboard; AXO_WB_BYPASS_EN adds a bypass
module axo_wb_arbiter
    import axo_defines::*;
#(
    parameter int XLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*AXO_REGIDX_W-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0]           req_data,
    input  logic                           claim_en,
    input  axo_regidx_t                    claim_rd,
    output logic [AXO_NREGS-1:0]           busy,
`ifdef AXO_WB_BYPASS_EN
    input  axo_regidx_t                    byp_rs1,
    input  axo_regidx_t                    byp_rs2,
    output logic                           byp_hit1,
    output logic                           byp_hit2,
    output logic [XLEN-1:0]                byp_data,
`endif
    output logic                           rf_we,
    output axo_regidx_t                    rf_rd,
    output logic [XLEN-1:0]                rf_din
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        gidx;
    logic [NREQ-1:0]      grant;
    axo_regidx_t          sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic [AXO_NREGS-1:0] busy_q;
    logic [AXO_NREGS-1:0] busy_nxt;

    axo_rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign req_ready = grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*AXO_REGIDX_W +: AXO_REGIDX_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            rf_we  <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
        end else if (|grant) begin
            ptr    <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            // x0 writes are consumed from the requester but never reach the regfile
            rf_we  <= (sel_rd != '0);
            rf_rd  <= sel_rd;
            rf_din <= sel_data;
        end else begin
            rf_we  <= 1'b0;
        end
    end

    // Clear is applied before set so a new producer claiming the same index keeps it busy
    always_comb begin
        busy_nxt = busy_q;
        if (rf_we) busy_nxt[rf_rd] = 1'b0;
        if (claim_en && claim_rd != '0) busy_nxt[claim_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

`ifdef AXO_WB_BYPASS_EN
    logic [AXO_NREGS-1:0] wb_mask;

    assign wb_mask  = rf_we ? (AXO_NREGS'(1) << rf_rd) : '0;
    assign busy     = busy_q & ~wb_mask;
    assign byp_hit1 = rf_we && (rf_rd != '0) && (rf_rd == byp_rs1);
    assign byp_hit2 = rf_we && (rf_rd != '0) && (rf_rd == byp_rs2);
    assign byp_data = rf_din;
`else
    assign busy = busy_q;
`endif

endmodule
